// File: rtl/me_pkg.sv
// Shared types and default dimensions for the motion-estimation engine and
// its memory-side reference server. Both sides import this so pixel widths
// and default block sizes cannot drift apart.
package me_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } srv_state_t;

   localparam int MACRO_DIM_D  = 4;
   localparam int SEARCH_DIM_D = 16;

endpackage

// File: rtl/me_search_buf.sv
// Search-window pixel store: one full row written per cycle, and a windowed
// read of MACRO_DIM+1 adjacent pixels from one row, registered so data for a
// request sampled at edge n appears right after edge n. Lanes that fall off
// the right edge of the window, and every lane of an out-of-range row, read 0.
module me_search_buf
   import me_pkg::*;
#(
   parameter int MACRO_DIM  = MACRO_DIM_D,
   parameter int SEARCH_DIM = SEARCH_DIM_D
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [5:0]                    wr_row,
   input  logic [8*SEARCH_DIM-1:0]       wr_data,
   input  logic                          rd_en,
   input  logic [5:0]                    rd_addr,
   input  logic [5:0]                    rd_amt,
   output logic [8*(MACRO_DIM+1)-1:0]    rd_data,
   output logic                          rd_oor
);

   localparam int AW = $clog2(SEARCH_DIM);
   // 7-bit limit so row/column compares never wrap, even at SEARCH_DIM = 64
   localparam logic [6:0] SD7 = 7'(SEARCH_DIM);

   pixel_t                    mem [SEARCH_DIM][SEARCH_DIM];
   logic                      wr_row_ok;
   logic                      rd_row_ok;
   logic [6:0]                col;
   logic [8*(MACRO_DIM+1)-1:0] rd_next;

   assign wr_row_ok = ({1'b0, wr_row} < SD7);
   assign rd_row_ok = ({1'b0, rd_addr} < SD7);
   assign rd_oor    = rd_en & ~rd_row_ok;

   // Row write; rows beyond the window are silently dropped
   always_ff @(posedge clk) begin
      if (wr_en && wr_row_ok) begin
         for (int c = 0; c < SEARCH_DIM; c++) begin
            mem[wr_row[AW-1:0]][c] <= wr_data[8*c +: 8];
         end
      end
   end

   // Windowed lane select with zero-fill past the window edges
   always_comb begin
      rd_next = '0;
      col     = '0;
      for (int k = 0; k <= MACRO_DIM; k++) begin
         col = {1'b0, rd_amt} + 7'(k);
         if (rd_row_ok && (col < SD7)) begin
            rd_next[8*k +: 8] = mem[rd_addr[AW-1:0]][col[AW-1:0]];
         end
      end
   end

   // Read register; holds its value while no request is presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_next;
      end
   end

endmodule

// File: rtl/me_ref_server.sv
// Memory-side responder and sequencer for the motion-estimation engine.
// Holds the search window and current macroblock, starts one search on host
// request, serves the engine's row reads with one cycle of latency, and
// presents the returned motion vector and SAD to the host.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | host may write rows; go launches a search
// S_START | waiting for the engine to be ready; me_start pulses once
// S_RUN   | engine searching; me_readyo high until its result arrives
// S_DONE  | result held on res_* until the host accepts it
module me_ref_server
   import me_pkg::*;
#(
   parameter int MACRO_DIM  = MACRO_DIM_D,
   parameter int SEARCH_DIM = SEARCH_DIM_D
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic                          wr_sel,
   input  logic [5:0]                    wr_row,
   input  logic [8*SEARCH_DIM-1:0]       wr_data,
   input  logic                          go,
   output logic                          busy,
   output logic                          me_start,
   input  logic                          me_readyi,
   input  logic                          me_en_ram,
   input  logic [5:0]                    me_addr,
   input  logic [5:0]                    me_amt,
   output logic [8*(MACRO_DIM+1)-1:0]    pixel_spr_out,
   output logic [8*MACRO_DIM-1:0]        pixel_cpr_out,
   output logic                          me_readyo,
   input  logic                          me_valido,
   input  logic [5:0]                    me_mv_x,
   input  logic [5:0]                    me_mv_y,
   input  logic [15:0]                   me_min_sad,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [5:0]                    res_mv_x,
   output logic [5:0]                    res_mv_y,
   output logic [15:0]                   res_sad,
   output logic                          rd_err
);

   localparam int MW = $clog2(MACRO_DIM);

   srv_state_t state;
   pixel_t     cur_mem [MACRO_DIM][MACRO_DIM];
   logic       wr_fire;
   logic       go_acc;
   logic       rd_oor;

   // Handshake outputs decode straight from the state register
   assign wr_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign me_readyo = (state == S_RUN);
   assign res_valid = (state == S_DONE);
   assign me_start  = (state == S_START) & me_readyi;

   assign wr_fire = wr_valid & wr_ready;
   assign go_acc  = (state == S_IDLE) & go;

   me_search_buf #(
      .MACRO_DIM  (MACRO_DIM),
      .SEARCH_DIM (SEARCH_DIM)
   ) u_search_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire & ~wr_sel),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .rd_en   (me_en_ram),
      .rd_addr (me_addr),
      .rd_amt  (me_amt),
      .rd_data (pixel_spr_out),
      .rd_oor  (rd_oor)
   );

   // Current-block row write; row index wraps modulo the block edge
   always_ff @(posedge clk) begin
      if (wr_fire && wr_sel) begin
         for (int j = 0; j < MACRO_DIM; j++) begin
            cur_mem[wr_row[MW-1:0]][j] <= wr_data[8*j +: 8];
         end
      end
   end

   // Current-block read register, same latency and hold rule as the search side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_cpr_out <= '0;
      end else if (me_en_ram) begin
         for (int k = 0; k < MACRO_DIM; k++) begin
            pixel_cpr_out[8*k +: 8] <= cur_mem[me_addr[MW-1:0]][k];
         end
      end
   end

   // Sticky out-of-range flag; a new error in the go cycle still registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_err <= 1'b0;
      end else if (rd_oor) begin
         rd_err <= 1'b1;
      end else if (go_acc) begin
         rd_err <= 1'b0;
      end
   end

   // Search sequencing and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         res_mv_x <= '0;
         res_mv_y <= '0;
         res_sad  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) state <= S_START;
            end
            S_START: begin
               if (me_readyi) state <= S_RUN;
            end
            S_RUN: begin
               if (me_valido) begin
                  res_mv_x <= me_mv_x;
                  res_mv_y <= me_mv_y;
                  res_sad  <= me_min_sad;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_me_ref_server.sv
// Directed bench for me_ref_server: loads a known search window and current
// block, exercises windowed reads and their edges, and walks the search
// handshake through start, result capture, host accept and reset.
module tb_me_ref_server;

   localparam int MD = 4;
   localparam int SD = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 wr_valid;
   logic                 wr_ready;
   logic                 wr_sel;
   logic [5:0]           wr_row;
   logic [8*SD-1:0]      wr_data;
   logic                 go;
   logic                 busy;
   logic                 me_start;
   logic                 me_readyi;
   logic                 me_en_ram;
   logic [5:0]           me_addr;
   logic [5:0]           me_amt;
   logic [8*(MD+1)-1:0]  pixel_spr_out;
   logic [8*MD-1:0]      pixel_cpr_out;
   logic                 me_readyo;
   logic                 me_valido;
   logic [5:0]           me_mv_x;
   logic [5:0]           me_mv_y;
   logic [15:0]          me_min_sad;
   logic                 res_valid;
   logic                 res_ready;
   logic [5:0]           res_mv_x;
   logic [5:0]           res_mv_y;
   logic [15:0]          res_sad;
   logic                 rd_err;

   int n_cmp = 0;
   int n_err = 0;

   me_ref_server #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_sel        (wr_sel),
      .wr_row        (wr_row),
      .wr_data       (wr_data),
      .go            (go),
      .busy          (busy),
      .me_start      (me_start),
      .me_readyi     (me_readyi),
      .me_en_ram     (me_en_ram),
      .me_addr       (me_addr),
      .me_amt        (me_amt),
      .pixel_spr_out (pixel_spr_out),
      .pixel_cpr_out (pixel_cpr_out),
      .me_readyo     (me_readyo),
      .me_valido     (me_valido),
      .me_mv_x       (me_mv_x),
      .me_mv_y       (me_mv_y),
      .me_min_sad    (me_min_sad),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_mv_x      (res_mv_x),
      .res_mv_y      (res_mv_y),
      .res_sad       (res_sad),
      .rd_err        (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_req(input logic [5:0] a, input logic [5:0] m);
      me_en_ram = 1'b1;
      me_addr   = a;
      me_amt    = m;
      tick();
      me_en_ram = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wr_valid = 0; wr_sel = 0; wr_row = 0; wr_data = '0; go = 0;
      me_readyi = 0; me_en_ram = 0; me_addr = 0; me_amt = 0;
      me_valido = 0; me_mv_x = 0; me_mv_y = 0; me_min_sad = 0; res_ready = 0;
      tick();
      tick();
      chk("rst_wr_ready",  64'(wr_ready),  64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_me_start",  64'(me_start),  64'd0);
      chk("rst_readyo",    64'(me_readyo), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_rd_err",    64'(rd_err),    64'd0);
      chk("rst_spr",       64'(pixel_spr_out), 64'd0);
      chk("rst_cpr",       64'(pixel_cpr_out), 64'd0);
      chk("rst_res_sad",   64'(res_sad),   64'd0);
      rst = 1'b0;
      tick();

      // search[r][c] = r*16+c
      for (int r = 0; r < SD; r++) begin
         wr_valid = 1; wr_sel = 0; wr_row = 6'(r);
         for (int c = 0; c < SD; c++) wr_data[8*c +: 8] = 8'(r*16 + c);
         tick();
      end
      // cur[i][j] = 0x80+4i+j
      for (int i = 0; i < MD; i++) begin
         wr_valid = 1; wr_sel = 1; wr_row = 6'(i);
         wr_data = '0;
         for (int j = 0; j < MD; j++) wr_data[8*j +: 8] = 8'(8'h80 + 4*i + j);
         tick();
      end
      wr_valid = 0;

      read_req(6'd3, 6'd5);
      chk("rd_3_5_spr", 64'(pixel_spr_out), 64'h39_38_37_36_35);
      chk("rd_3_5_cpr", 64'(pixel_cpr_out), 64'h8F_8E_8D_8C);
      me_addr = 6'd1;
      tick();
      chk("hold_spr", 64'(pixel_spr_out), 64'h39_38_37_36_35);
      chk("hold_cpr", 64'(pixel_cpr_out), 64'h8F_8E_8D_8C);

      read_req(6'd2, 6'd13);
      chk("rd_2_13_spr", 64'(pixel_spr_out), 64'h00_00_2F_2E_2D);
      chk("rd_2_13_cpr", 64'(pixel_cpr_out), 64'h8B_8A_89_88);
      chk("rd_2_13_err", 64'(rd_err), 64'd0);
      read_req(6'd1, 6'd62);
      chk("rd_amt62_spr", 64'(pixel_spr_out), 64'd0);
      chk("rd_amt62_err", 64'(rd_err), 64'd0);
      read_req(6'd17, 6'd0);
      chk("rd_17_spr", 64'(pixel_spr_out), 64'd0);
      chk("rd_17_cpr", 64'(pixel_cpr_out), 64'h87_86_85_84);
      chk("rd_17_err", 64'(rd_err), 64'd1);
      tick();
      chk("rd_err_sticky", 64'(rd_err), 64'd1);

      // go with engine not ready for 3 cycles
      go = 1;
      tick();
      go = 0;
      chk("start_busy",     64'(busy),     64'd1);
      chk("start_wr_ready", 64'(wr_ready), 64'd0);
      chk("start_err_clr",  64'(rd_err),   64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("start_wait_me_start", 64'(me_start),  64'd0);
         chk("start_wait_readyo",   64'(me_readyo), 64'd0);
         tick();
      end
      me_readyi = 1;
      #1;
      chk("start_pulse", 64'(me_start), 64'd1);
      tick();
      chk("run_me_start", 64'(me_start),  64'd0);
      chk("run_readyo",   64'(me_readyo), 64'd1);
      me_readyi = 0;

      // host write attempt during RUN is refused
      wr_valid = 1; wr_sel = 0; wr_row = 6'd3;
      for (int c = 0; c < SD; c++) wr_data[8*c +: 8] = 8'hEE;
      #1;
      chk("run_wr_ready", 64'(wr_ready), 64'd0);
      tick();
      wr_valid = 0;
      read_req(6'd3, 6'd5);
      chk("run_mem_unchanged", 64'(pixel_spr_out), 64'h39_38_37_36_35);

      // result capture
      me_valido = 1; me_mv_x = 6'd7; me_mv_y = 6'd9; me_min_sad = 16'h0123;
      tick();
      me_valido = 0; me_mv_x = 6'd1; me_mv_y = 6'd2; me_min_sad = 16'hFFFF;
      chk("done_res_valid", 64'(res_valid), 64'd1);
      chk("done_mv_x",      64'(res_mv_x),  64'd7);
      chk("done_mv_y",      64'(res_mv_y),  64'd9);
      chk("done_sad",       64'(res_sad),   64'h0123);
      chk("done_readyo",    64'(me_readyo), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("done_hold_valid", 64'(res_valid), 64'd1);
         chk("done_hold_sad",   64'(res_sad),   64'h0123);
         chk("done_hold_mv_x",  64'(res_mv_x),  64'd7);
      end
      res_ready = 1;
      tick();
      res_ready = 0;
      chk("accept_wr_ready",  64'(wr_ready),  64'd1);
      chk("accept_busy",      64'(busy),      64'd0);
      chk("accept_res_valid", 64'(res_valid), 64'd0);

      // go together with a current-row write (row 6 lands in row 2)
      wr_valid = 1; wr_sel = 1; wr_row = 6'd6; wr_data = '0;
      for (int j = 0; j < MD; j++) wr_data[8*j +: 8] = 8'(8'h90 + j);
      go = 1;
      tick();
      wr_valid = 0; go = 0;
      chk("gowr_busy",     64'(busy),     64'd1);
      chk("gowr_wr_ready", 64'(wr_ready), 64'd0);
      read_req(6'd2, 6'd0);
      chk("gowr_cpr", 64'(pixel_cpr_out), 64'h93_92_91_90);
      chk("gowr_spr", 64'(pixel_spr_out), 64'h24_23_22_21_20);
      me_readyi = 1;
      tick();
      me_readyi = 0;
      chk("gowr_run", 64'(me_readyo), 64'd1);

      // reset while in RUN
      rst = 1;
      #1;
      chk("rstrun_busy",      64'(busy),      64'd0);
      chk("rstrun_wr_ready",  64'(wr_ready),  64'd1);
      chk("rstrun_readyo",    64'(me_readyo), 64'd0);
      chk("rstrun_res_valid", 64'(res_valid), 64'd0);
      chk("rstrun_res_sad",   64'(res_sad),   64'd0);
      chk("rstrun_spr",       64'(pixel_spr_out), 64'd0);
      chk("rstrun_cpr",       64'(pixel_cpr_out), 64'd0);
      tick();
      rst = 0;
      tick();

      // fresh search after reset; memory survives reset
      read_req(6'd3, 6'd5);
      chk("post_rst_mem", 64'(pixel_spr_out), 64'h39_38_37_36_35);
      go = 1;
      tick();
      go = 0;
      me_readyi = 1;
      #1;
      chk("post_rst_start", 64'(me_start), 64'd1);
      tick();
      me_readyi = 0;
      me_valido = 1; me_mv_x = 6'd3; me_mv_y = 6'd4; me_min_sad = 16'h0042;
      tick();
      me_valido = 0;
      chk("post_rst_valid", 64'(res_valid), 64'd1);
      chk("post_rst_mv_x",  64'(res_mv_x),  64'd3);
      chk("post_rst_mv_y",  64'(res_mv_y),  64'd4);
      chk("post_rst_sad",   64'(res_sad),   64'h0042);
      res_ready = 1;
      tick();
      res_ready = 0;
      chk("post_rst_idle", 64'(wr_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
